// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and loader types.
// The opcodes match the maindec decode map, including the sb/ble/li extensions.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BLE   = 6'b011111;
  localparam logic [5:0] OP_LI    = 6'b010001;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_SLT  = 4'd4,
    K_LW   = 4'd5,
    K_SW   = 4'd6,
    K_BEQ  = 4'd7,
    K_ADDI = 4'd8,
    K_J    = 4'd9,
    K_SB   = 4'd10,
    K_BLE  = 4'd11,
    K_LI   = 4'd12
  } kind_e;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } loader_state_e;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder: symbolic request -> 32-bit MIPS word plus legal flag.
module instr_encode
  import mips_pkg::*;
(
  input  logic [3:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [25:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_legal
);

  logic [15:0] w_imm16;

  assign w_imm16 = i_imm[15:0];

  always_comb begin
    o_word  = '0;
    o_legal = 1'b1;
    case (i_kind)
      K_ADD:   o_word = enc_r(i_rs, i_rt, i_rd, FN_ADD);
      K_SUB:   o_word = enc_r(i_rs, i_rt, i_rd, FN_SUB);
      K_AND:   o_word = enc_r(i_rs, i_rt, i_rd, FN_AND);
      K_OR:    o_word = enc_r(i_rs, i_rt, i_rd, FN_OR);
      K_SLT:   o_word = enc_r(i_rs, i_rt, i_rd, FN_SLT);
      K_LW:    o_word = enc_i(OP_LW,   i_rs, i_rt, w_imm16);
      K_SW:    o_word = enc_i(OP_SW,   i_rs, i_rt, w_imm16);
      K_BEQ:   o_word = enc_i(OP_BEQ,  i_rs, i_rt, w_imm16);
      K_ADDI:  o_word = enc_i(OP_ADDI, i_rs, i_rt, w_imm16);
      K_SB:    o_word = enc_i(OP_SB,   i_rs, i_rt, w_imm16);
      K_BLE:   o_word = enc_i(OP_BLE,  i_rs, i_rt, w_imm16);
      // li has no source register; rs is forced to zero
      K_LI:    o_word = enc_i(OP_LI,   5'd0, i_rt, w_imm16);
      K_J:     o_word = {OP_J, i_imm};
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// Loads encoded instructions into imem one word per two cycles and holds the
// CPU in reset until the final instruction has been written.
module imem_program_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [3:0]        i_in_kind,
  input  logic [4:0]        i_in_rs,
  input  logic [4:0]        i_in_rt,
  input  logic [4:0]        i_in_rd,
  input  logic [25:0]       i_in_imm,
  input  logic              i_in_last,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wd,
  output logic              o_cpu_hold,
  output logic              o_err,
  output logic [ADDR_W:0]   o_count
);

  localparam int CNT_W = ADDR_W + 1;

  loader_state_e     r_state;
  loader_state_e     w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wd;
  logic              r_last;
  logic              r_armed;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       w_word;
  logic              w_legal;
  logic              w_accept;

  instr_encode u_encode (
    .i_kind  (i_in_kind),
    .i_rs    (i_in_rs),
    .i_rt    (i_in_rt),
    .i_rd    (i_in_rd),
    .i_imm   (i_in_imm),
    .o_word  (w_word),
    .o_legal (w_legal)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_LOAD;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= 1'b1;
    end
  end

  // r_armed keeps ready low while reset is asserted and for the first edge after it
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    o_in_ready  = 1'b0;
    o_imem_we   = 1'b0;
    o_cpu_hold  = 1'b1;
    o_err       = 1'b0;
    case (r_state)
      ST_LOAD: begin
        o_in_ready = r_armed;
        if (i_in_valid && r_armed) begin
          w_accept    = w_legal;
          w_state_nxt = w_legal ? ST_WRITE : ST_ERROR;
        end
      end
      ST_WRITE: begin
        o_imem_we = 1'b1;
        if (r_last) begin
          w_state_nxt = ST_DONE;
        end else if (r_addr == {ADDR_W{1'b1}}) begin
          w_state_nxt = ST_ERROR;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_DONE: begin
        o_cpu_hold = 1'b0;
      end
      ST_ERROR: begin
        o_err = 1'b1;
      end
      default: begin
        w_state_nxt = ST_ERROR;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr  <= ADDR_W'(BASE_ADDR);
      r_wd    <= '0;
      r_last  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_wd   <= w_word;
        r_last <= i_in_last;
      end
      // overflow wraps the address to zero; it is never used again from ERROR
      if (r_state == ST_WRITE) begin
        r_addr  <= r_addr + ADDR_W'(1);
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_imem_addr = r_addr;
  assign o_imem_wd   = r_wd;
  assign o_count     = r_count;

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: directed table, corner sequences,
// and randomized programs against an arithmetic encoding model.
module tb_imem_program_loader;

  logic        clk;
  logic        rst1, rst2;
  logic        valid1, valid2;
  logic [3:0]  kind;
  logic [4:0]  rs, rt, rd;
  logic [25:0] imm;
  logic        last_i;

  logic        ready1, we1, hold1, err1;
  logic [5:0]  addr1;
  logic [31:0] wd1;
  logic [6:0]  count1;
  logic        ready2, we2, hold2, err2;
  logic [1:0]  addr2;
  logic [31:0] wd2;
  logic [2:0]  count2;

  int checks = 0;
  int errors = 0;

  imem_program_loader #(.ADDR_W(6), .BASE_ADDR(0)) dut (
    .i_clk(clk), .i_rst(rst1), .i_in_valid(valid1), .o_in_ready(ready1),
    .i_in_kind(kind), .i_in_rs(rs), .i_in_rt(rt), .i_in_rd(rd), .i_in_imm(imm),
    .i_in_last(last_i), .o_imem_we(we1), .o_imem_addr(addr1), .o_imem_wd(wd1),
    .o_cpu_hold(hold1), .o_err(err1), .o_count(count1)
  );

  imem_program_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_in_valid(valid2), .o_in_ready(ready2),
    .i_in_kind(kind), .i_in_rs(rs), .i_in_rt(rt), .i_in_rd(rd), .i_in_imm(imm),
    .i_in_last(last_i), .o_imem_we(we2), .o_imem_addr(addr2), .o_imem_wd(wd2),
    .o_cpu_hold(hold2), .o_err(err2), .o_count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    int          rs;
    int          rt;
    int          rd;
    int          imm;
    bit          last;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] ref_enc(input int k, input int r_s, input int r_t,
                                          input int r_d, input int im);
    longint op;
    longint fn;
    longint v;
    op = 0;
    fn = 0;
    case (k)
      0: fn = 32;  1: fn = 34;  2: fn = 36;  3: fn = 37;  4: fn = 42;
      5: op = 35;  6: op = 43;  7: op = 4;   8: op = 8;   9: op = 2;
      10: op = 40; 11: op = 31; 12: op = 17;
      default: op = 0;
    endcase
    if (k <= 4)
      v = longint'(r_s) * (1 << 21) + longint'(r_t) * (1 << 16) + longint'(r_d) * (1 << 11) + fn;
    else if (k == 9)
      v = op * (longint'(1) << 26) + longint'(im % (1 << 26));
    else if (k == 12)
      v = op * (longint'(1) << 26) + longint'(r_t) * (1 << 16) + longint'(im % 65536);
    else
      v = op * (longint'(1) << 26) + longint'(r_s) * (1 << 21) + longint'(r_t) * (1 << 16)
          + longint'(im % 65536);
    return 32'(v);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic g_ready(input int w); return w != 0 ? ready2 : ready1; endfunction
  function automatic logic g_we(input int w);    return w != 0 ? we2 : we1;       endfunction
  function automatic logic g_hold(input int w);  return w != 0 ? hold2 : hold1;   endfunction
  function automatic logic g_err(input int w);   return w != 0 ? err2 : err1;     endfunction
  function automatic int   g_addr(input int w);  return w != 0 ? int'(addr2) : int'(addr1);   endfunction
  function automatic int   g_count(input int w); return w != 0 ? int'(count2) : int'(count1); endfunction
  function automatic logic [31:0] g_wd(input int w); return w != 0 ? wd2 : wd1; endfunction

  task automatic check_reset_vals(input int w);
    chk("rst_ready", g_ready(w), 0);
    chk("rst_we",    g_we(w),    0);
    chk("rst_addr",  g_addr(w),  0);
    chk("rst_wd",    g_wd(w),    0);
    chk("rst_hold",  g_hold(w),  1);
    chk("rst_err",   g_err(w),   0);
    chk("rst_count", g_count(w), 0);
  endtask

  // Called at a negedge; returns at the following negedge with reset released.
  task automatic do_reset(input int w);
    valid1 = 1'b0;
    valid2 = 1'b0;
    if (w != 0) rst2 = 1'b1; else rst1 = 1'b1;
    @(negedge clk);
    check_reset_vals(w);
    if (w != 0) rst2 = 1'b0; else rst1 = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns #1 after the accepting posedge.
  task automatic send(input int w, input int k, input int r_s, input int r_t, input int r_d,
                      input int im, input bit lst);
    bit ok;
    ok = 1'b0;
    kind = 4'(k); rs = 5'(r_s); rt = 5'(r_t); rd = 5'(r_d); imm = 26'(im); last_i = lst;
    if (w != 0) valid2 = 1'b1; else valid1 = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (g_ready(w)) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    valid1 = 1'b0;
    valid2 = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1 at %0t", $time);
    end
  endtask

  task automatic write_check(input int w, input int e_addr, input logic [31:0] e_wd,
                             input int e_count);
    @(negedge clk);
    chk("wr_we",   g_we(w),   1);
    chk("wr_addr", g_addr(w), e_addr);
    chk("wr_wd",   g_wd(w),   e_wd);
    chk("wr_hold", g_hold(w), 1);
    chk("wr_ready", g_ready(w), 0);
    @(negedge clk);
    chk("wr_we_off", g_we(w),   0);
    chk("wr_count",  g_count(w), e_count);
  endtask

  initial begin
    int n;
    int k, a, b, c, im;
    logic [31:0] e;
    rst1 = 1'b1; rst2 = 1'b1; valid1 = 1'b0; valid2 = 1'b0;
    kind = '0; rs = '0; rt = '0; rd = '0; imm = '0; last_i = 1'b0;

    vecs[0] = '{0,  1,  2, 3, 0,       1'b0, 32'h00221820};
    vecs[1] = '{5,  29, 8, 0, 4,       1'b0, 32'h8FA80004};
    vecs[2] = '{12, 7,  9, 0, 'h1234,  1'b0, 32'h44091234};
    vecs[3] = '{11, 4,  5, 0, 'h3FFFE, 1'b0, 32'h7C85FFFE};
    vecs[4] = '{10, 3,  2, 0, 1,       1'b0, 32'hA0620001};
    vecs[5] = '{9,  0,  0, 0, 'h10,    1'b1, 32'h08000010};

    @(negedge clk);
    check_reset_vals(0);
    rst1 = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);

    // Directed program through the 64-word loader
    for (int i = 0; i < 6; i++) begin
      send(0, vecs[i].k, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].last);
      write_check(0, i, vecs[i].exp_wd, i + 1);
    end
    chk("done_hold", hold1, 0);
    chk("done_ready", ready1, 0);
    chk("done_err", err1, 0);
    kind = 4'd0; valid1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("done_no_we", we1, 0);
    end
    valid1 = 1'b0;
    chk("done_count", count1, 6);
    chk("done_hold2", hold1, 0);

    // Illegal kind
    do_reset(0);
    send(0, 14, 1, 2, 3, 5, 1'b0);
    @(negedge clk);
    chk("ill_we", we1, 0);
    chk("ill_err", err1, 1);
    chk("ill_hold", hold1, 1);
    chk("ill_ready", ready1, 0);
    @(negedge clk);
    chk("ill_count", count1, 0);
    chk("ill_err_sticky", err1, 1);

    // Reset asserted while the word is being written
    do_reset(0);
    send(0, 1, 4, 5, 6, 0, 1'b0);
    @(negedge clk);
    chk("midrst_we_before", we1, 1);
    rst1 = 1'b1;
    #1;
    check_reset_vals(0);
    @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    send(0, 3, 7, 8, 9, 0, 1'b0);
    write_check(0, 0, ref_enc(3, 7, 8, 9, 0), 1);

    // Randomized programs checked against the arithmetic model
    for (int p = 0; p < 4; p++) begin
      do_reset(0);
      n = $urandom_range(3, 20);
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 12);
        a = $urandom_range(0, 31);
        b = $urandom_range(0, 31);
        c = $urandom_range(0, 31);
        im = int'($urandom_range(0, 32'h3FFFFFF));
        e = ref_enc(k, a, b, c, im);
        send(0, k, a, b, c, im, i == n - 1);
        write_check(0, i, e, i + 1);
      end
      chk("rnd_done_hold", hold1, 0);
      chk("rnd_done_err", err1, 0);
    end

    // Four-word loader: overflow without last
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      send(1, 8, i, i + 1, 0, i * 3, 1'b0);
      write_check(1, i, ref_enc(8, i, i + 1, 0, i * 3), i + 1);
    end
    chk("ovf_err", err2, 1);
    chk("ovf_count", count2, 4);
    chk("ovf_hold", hold2, 1);
    chk("ovf_ready", ready2, 0);

    // Four-word loader: last on the final slot finishes cleanly
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      send(1, 6, 2, i, 0, 100 + i, i == 3);
      write_check(1, i, ref_enc(6, 2, i, 0, 100 + i), i + 1);
    end
    chk("full_err", err2, 0);
    chk("full_hold", hold2, 0);
    chk("full_count", count2, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
